// File: rtl/f3m_mult_pkg.sv
// Shared constants, state type and GF(3) coefficient cells for the GF(3^97) serial multiplier.
// Build option: F3M_MULT_DIGIT2_EN selects the two-coefficients-per-cycle variant.
package f3m_mult_pkg;

  localparam int unsigned M               = 97;
  localparam int unsigned W               = 2 * M - 1;
  localparam int unsigned TAP             = 12;
  localparam int unsigned CNT_W           = 7;
  localparam int unsigned CNT_INIT_SERIAL = M - 1;
  localparam int unsigned CNT_INIT_DIGIT2 = (M + 1) / 2 - 1;

  localparam logic [1:0] GF3_ZERO = 2'b00;
  localparam logic [1:0] GF3_ONE  = 2'b01;
  localparam logic [1:0] GF3_TWO  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = 3'(x) + 3'(y);
    return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
  endfunction

  // Negation swaps the codes for 1 and 2 and leaves 0 alone.
  function automatic logic [1:0] gf3_neg(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [1:0] gf3_sub(input logic [1:0] x, input logic [1:0] y);
    return gf3_add(x, gf3_neg(y));
  endfunction

  function automatic logic [1:0] gf3_mul(input logic [1:0] x, input logic [1:0] y);
    if (x == GF3_ZERO || y == GF3_ZERO) return GF3_ZERO;
    return (x == y) ? GF3_ONE : GF3_TWO;
  endfunction

endpackage

// File: rtl/f3m_mult_step.sv
// One Horner step: y_c = x*acc mod (x^97 + x^12 + 2) + d*a, coefficient-wise in GF(3).
module f3m_mult_step
  import f3m_mult_pkg::*;
(
  input  logic [W:0] acc,
  input  logic [1:0] d,
  input  logic [W:0] a,
  output logic [W:0] y_c
);

  logic [W+2:0] sh;
  logic [1:0]   top;

  assign sh  = {acc, 2'b00};
  assign top = sh[W+2:W+1];

  // x^97 folds back onto coefficients 0 and TAP.
  for (genvar i = 0; i < M; i++) begin : g_coef
    logic [1:0] xc;
    if (i == 0) begin : g_c0
      assign xc = gf3_sub(GF3_ZERO, gf3_mul(GF3_TWO, top));
    end else if (i == TAP) begin : g_tap
      assign xc = gf3_sub(sh[2*i+1:2*i], top);
    end else begin : g_mid
      assign xc = sh[2*i+1:2*i];
    end
    assign y_c[2*i+1:2*i] = gf3_add(xc, gf3_mul(d, a[2*i+1:2*i]));
  end

endmodule

// File: rtl/f3m_mult_serial.sv
// Coefficient-serial GF(3^97) multiplier, MSB-first Horner accumulation of C = A*B mod p.
// Build option: F3M_MULT_DIGIT2_EN consumes two coefficients of B per cycle.
module f3m_mult_serial
  import f3m_mult_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [W:0] a,
  input  logic [W:0] b,
  output logic [W:0] c,
  output logic       busy,
  output logic       done
);

  state_t             state_q, state_d;
  logic [W:0]         ra_q, ra_d;
  logic [W:0]         rb_q, rb_d;
  logic [W:0]         acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W:0]         c_d;
  logic               busy_d, done_d;
  logic [W:0]         step_y;

`ifdef F3M_MULT_DIGIT2_EN
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_DIGIT2);

  logic [W+2:0] rb_ext;
  logic [1:0]   d_hi, d_lo;
  logic [W:0]   y_hi;

  // B is padded to 98 coefficients so pairs divide evenly.
  assign rb_ext = {2'b00, rb_q};
  assign d_hi   = rb_ext[{cnt_q, 2'b10} +: 2];
  assign d_lo   = rb_ext[{cnt_q, 2'b00} +: 2];

  f3m_mult_step u_step_hi (.acc(acc_q), .d(d_hi), .a(ra_q), .y_c(y_hi));
  f3m_mult_step u_step_lo (.acc(y_hi),  .d(d_lo), .a(ra_q), .y_c(step_y));
`else
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_SERIAL);

  logic [1:0] d_cur;

  assign d_cur = rb_q[{cnt_q, 1'b0} +: 2];

  f3m_mult_step u_step (.acc(acc_q), .d(d_cur), .a(ra_q), .y_c(step_y));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c       <= c_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and datapath control; done is a single-cycle pulse by default-clear.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_y;
        if (cnt_q == '0) begin
          c_d     = step_y;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
